// File: rtl/psu_sweep_ctrl.sv
// rtl/psu_sweep_ctrl.sv - holds one PSU mask set and sweeps uc/qb demux selects as paced beats
module psu_sweep_ctrl #(
  parameter int NUM_PCU     = 4,
  parameter int NUM_PCUQB   = 16,
  parameter int PCHADDR_BW  = 4,
  parameter int NUM_UCC     = 2,
  parameter int NUM_UC      = 4,
  parameter int NUM_QBCTRL  = 2,
  parameter int NUM_QB      = 4,
  parameter int UCADDR_BW   = 2,
  parameter int QBADDR_BW   = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUM_PCU*PCHADDR_BW-1:0]     pchidx_in,
  input  logic [NUM_PCU-1:0]                pivalid_in,
  input  logic [NUM_PCU*NUM_PCUQB-1:0]      mask_in,
  input  logic [NUM_PCU*NUM_PCUQB-1:0]      special_in,
  input  logic                              abort,
  output logic [NUM_PCU*PCHADDR_BW-1:0]     pchidx_list,
  output logic [NUM_PCU-1:0]                pivalid_list,
  output logic [NUM_PCU*NUM_PCUQB-1:0]      mask_array,
  output logic [NUM_PCU*NUM_PCUQB-1:0]      special_array,
  output logic [NUM_UCC*UCADDR_BW-1:0]      uc_counter,
  output logic [NUM_QBCTRL*QBADDR_BW-1:0]   qb_counter,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done
);
  localparam int UC_STEPS = NUM_UC / NUM_UCC;
  localparam int QB_STEPS = NUM_QB / NUM_QBCTRL;
  localparam int UCS_W    = (UC_STEPS > 1) ? $clog2(UC_STEPS) : 1;
  localparam int QBS_W    = (QB_STEPS > 1) ? $clog2(QB_STEPS) : 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t             state;
  logic [UCS_W-1:0]   uc_step;
  logic [QBS_W-1:0]   qb_step;
  logic               uc_end;
  logic               qb_end;

  assign uc_end   = (uc_step == UCS_W'(UC_STEPS - 1));
  assign qb_end   = (qb_step == QBS_W'(QB_STEPS - 1));
  assign out_last = (state == SWEEP) && uc_end && qb_end;

  // Lane values are formed at 32 bits and truncated to the address width.
  for (genvar j = 0; j < NUM_UCC; j++) begin : g_uc_lane
    assign uc_counter[j*UCADDR_BW +: UCADDR_BW] = UCADDR_BW'(32'(uc_step) * NUM_UCC + j);
  end
  for (genvar k = 0; k < NUM_QBCTRL; k++) begin : g_qb_lane
    assign qb_counter[k*QBADDR_BW +: QBADDR_BW] = QBADDR_BW'(32'(qb_step) * NUM_QBCTRL + k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      uc_step       <= '0;
      qb_step       <= '0;
      pchidx_list   <= '0;
      pivalid_list  <= '0;
      mask_array    <= '0;
      special_array <= '0;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // abort outranks a simultaneous offer: nothing is latched
          if (in_valid && !abort) begin
            pchidx_list   <= pchidx_in;
            pivalid_list  <= pivalid_in;
            mask_array    <= mask_in;
            special_array <= special_in;
            uc_step       <= '0;
            qb_step       <= '0;
            state         <= SWEEP;
            in_ready      <= 1'b0;
            out_valid     <= 1'b1;
            busy          <= 1'b1;
          end
        end
        SWEEP: begin
          if (abort) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (out_ready) begin
            if (!qb_end) begin
              qb_step <= qb_step + QBS_W'(1);
            end else begin
              qb_step <= '0;
              if (uc_end) begin
                state     <= DONE;
                out_valid <= 1'b0;
                done      <= 1'b1;
              end else begin
                uc_step <= uc_step + UCS_W'(1);
              end
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_psu_sweep_ctrl.sv
// tb/tb_psu_sweep_ctrl.sv - directed self-checking bench for psu_sweep_ctrl
module tb_psu_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, abort, out_valid, out_ready, out_last, busy, done;
  logic [15:0] pchidx_in, pchidx_list;
  logic [3:0]  pivalid_in, pivalid_list;
  logic [63:0] mask_in, special_in, mask_array, special_array;
  logic [3:0]  uc_counter, qb_counter;

  logic        in_valid_d, in_ready_d, out_valid_d, out_last_d, busy_d, done_d;
  logic        abort_d = 1'b0;
  logic        out_ready_d = 1'b1;
  logic [15:0] pchidx_list_d;
  logic [3:0]  pivalid_list_d;
  logic [63:0] mask_array_d, special_array_d;
  logic [3:0]  uc_counter_d, qb_counter_d;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  psu_sweep_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pchidx_in(pchidx_in), .pivalid_in(pivalid_in), .mask_in(mask_in), .special_in(special_in),
    .abort(abort), .pchidx_list(pchidx_list), .pivalid_list(pivalid_list),
    .mask_array(mask_array), .special_array(special_array),
    .uc_counter(uc_counter), .qb_counter(qb_counter),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  psu_sweep_ctrl #(.NUM_UC(2), .NUM_QB(2)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid_d), .in_ready(in_ready_d),
    .pchidx_in(pchidx_in), .pivalid_in(pivalid_in), .mask_in(mask_in), .special_in(special_in),
    .abort(abort_d), .pchidx_list(pchidx_list_d), .pivalid_list(pivalid_list_d),
    .mask_array(mask_array_d), .special_array(special_array_d),
    .uc_counter(uc_counter_d), .qb_counter(qb_counter_d),
    .out_valid(out_valid_d), .out_ready(out_ready_d), .out_last(out_last_d),
    .busy(busy_d), .done(done_d)
  );

  // Lanes packed {lane1, lane0}: (0,1) -> 4'h4, (2,3) -> 4'hE.
  function automatic logic [3:0] uc_exp(input int beat);
    return (beat < 2) ? 4'h4 : 4'hE;
  endfunction
  function automatic logic [3:0] qb_exp(input int beat);
    return (beat % 2 == 0) ? 4'h4 : 4'hE;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [63:0] m);
    in_valid   = 1'b1;
    mask_in    = m;
    special_in = ~m;
    step();
    in_valid   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if ({out_valid, out_last, busy, done} !== 4'b0000) begin failures++; $display("FAIL reset_flags got %b exp 0000", {out_valid, out_last, busy, done}); end
    checks++; if (uc_counter !== 4'h4 || qb_counter !== 4'h4) begin failures++; $display("FAIL reset_counters got %h/%h exp 4/4", uc_counter, qb_counter); end
    checks++; if (mask_array !== 64'h0 || pchidx_list !== 16'h0) begin failures++; $display("FAIL reset_held got %h/%h exp 0/0", mask_array, pchidx_list); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_sweep();
    start(64'h0000_0000_0000_A5A5);
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid beat %0d got %0b exp 1", i, out_valid); end
      checks++; if (uc_counter !== uc_exp(i) || qb_counter !== qb_exp(i)) begin failures++; $display("FAIL basic_counters beat %0d got %h/%h exp %h/%h", i, uc_counter, qb_counter, uc_exp(i), qb_exp(i)); end
      checks++; if (out_last !== (i == 3)) begin failures++; $display("FAIL basic_last beat %0d got %0b exp %0b", i, out_last, (i == 3)); end
      checks++; if (mask_array[15:0] !== 16'hA5A5) begin failures++; $display("FAIL basic_mask beat %0d got %h exp a5a5", i, mask_array[15:0]); end
      step();
    end
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_done got done=%0b valid=%0b exp 1/0", done, out_valid); end
    checks++; if (pchidx_list !== 16'h1234 || pivalid_list !== 4'b1011 || special_array !== ~64'hA5A5) begin failures++; $display("FAIL basic_held got %h %b %h", pchidx_list, pivalid_list, special_array); end
    step();
    checks++; if (done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL basic_idle got done=%0b rdy=%0b busy=%0b exp 0/1/0", done, in_ready, busy); end
  endtask

  task automatic test_backpressure();
    start(64'h1111);
    checks++; if (uc_counter !== 4'h4 || qb_counter !== 4'h4) begin failures++; $display("FAIL bp_beat1 got %h/%h exp 4/4", uc_counter, qb_counter); end
    step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b1 || uc_counter !== 4'h4 || qb_counter !== 4'hE) begin failures++; $display("FAIL bp_hold cycle %0d got v=%0b %h/%h exp 1 4/e", c, out_valid, uc_counter, qb_counter); end
      step();
    end
    out_ready = 1'b1;
    checks++; if (uc_counter !== 4'h4 || qb_counter !== 4'hE) begin failures++; $display("FAIL bp_hold4 got %h/%h exp 4/e", uc_counter, qb_counter); end
    step();
    for (int i = 2; i < 4; i++) begin
      checks++; if (uc_counter !== uc_exp(i) || qb_counter !== qb_exp(i) || out_last !== (i == 3)) begin failures++; $display("FAIL bp_beat %0d got %h/%h last=%0b", i, uc_counter, qb_counter, out_last); end
      step();
    end
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL bp_done got %0b exp 1", done); end
    step();
  endtask

  task automatic test_input_blocking();
    start(64'h2222);
    in_valid = 1'b1;
    mask_in  = 64'h9999;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b0 || mask_array !== 64'h2222) begin failures++; $display("FAIL block beat %0d got rdy=%0b mask=%h exp 0/2222", i, in_ready, mask_array); end
      step();
    end
    in_valid = 1'b0;
    checks++; if (done !== 1'b1 || mask_array !== 64'h2222) begin failures++; $display("FAIL block_done got done=%0b mask=%h exp 1/2222", done, mask_array); end
    step();
  endtask

  task automatic test_abort_idle();
    in_valid = 1'b1;
    abort    = 1'b1;
    mask_in  = 64'h7777;
    step();
    in_valid = 1'b0;
    abort    = 1'b0;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || mask_array !== 64'h2222) begin failures++; $display("FAIL abort_idle got busy=%0b rdy=%0b mask=%h exp 0/1/2222", busy, in_ready, mask_array); end
  endtask

  task automatic test_abort();
    start(64'h3333);
    step();
    step();
    checks++; if (uc_counter !== 4'hE || qb_counter !== 4'h4) begin failures++; $display("FAIL abort_beat3 got %h/%h exp e/4", uc_counter, qb_counter); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_idle_next got v=%0b r=%0b b=%0b d=%0b exp 0/1/0/0", out_valid, in_ready, busy, done); end
    step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_no_done got %0b exp 0", done); end
    start(64'h4444);
    checks++; if (out_valid !== 1'b1 || uc_counter !== 4'h4 || qb_counter !== 4'h4 || out_last !== 1'b0) begin failures++; $display("FAIL abort_restart got v=%0b %h/%h last=%0b", out_valid, uc_counter, qb_counter, out_last); end
    for (int i = 0; i < 4; i++) step();
    checks++; if (done !== 1'b1 || mask_array !== 64'h4444) begin failures++; $display("FAIL abort_restart_done got done=%0b mask=%h exp 1/4444", done, mask_array); end
    step();
  endtask

  task automatic test_reset_mid_sweep();
    start(64'h5555);
    step();
    rst = 1'b1;
    step();
    checks++; if ({in_ready, out_valid, out_last, busy, done} !== 5'b10000) begin failures++; $display("FAIL rst_mid_flags got %b exp 10000", {in_ready, out_valid, out_last, busy, done}); end
    checks++; if (uc_counter !== 4'h4 || qb_counter !== 4'h4 || mask_array !== 64'h0 || pivalid_list !== 4'h0) begin failures++; $display("FAIL rst_mid_values got %h/%h mask=%h pv=%b", uc_counter, qb_counter, mask_array, pivalid_list); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_degenerate();
    in_valid_d = 1'b1;
    mask_in    = 64'h6666;
    step();
    in_valid_d = 1'b0;
    checks++; if (out_valid_d !== 1'b1 || out_last_d !== 1'b1 || uc_counter_d !== 4'h4 || qb_counter_d !== 4'h4) begin failures++; $display("FAIL degen_beat got v=%0b last=%0b %h/%h exp 1/1 4/4", out_valid_d, out_last_d, uc_counter_d, qb_counter_d); end
    step();
    checks++; if (done_d !== 1'b1 || out_valid_d !== 1'b0 || mask_array_d !== 64'h6666) begin failures++; $display("FAIL degen_done got d=%0b v=%0b mask=%h exp 1/0/6666", done_d, out_valid_d, mask_array_d); end
    step();
    checks++; if (in_ready_d !== 1'b1 || done_d !== 1'b0) begin failures++; $display("FAIL degen_idle got r=%0b d=%0b exp 1/0", in_ready_d, done_d); end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_valid_d = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    pchidx_in  = 16'h1234;
    pivalid_in = 4'b1011;
    mask_in    = '0;
    special_in = '0;
    #1;
    test_reset();
    test_basic_sweep();
    test_backpressure();
    test_input_blocking();
    test_abort_idle();
    test_abort();
    test_reset_mid_sweep();
    test_degenerate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
